// File: rtl/prefix_add_pipe.sv
// ---------------------------------------------------------------------------
// prefix_add_pipe
//
// Pipelined Kogge-Stone parallel-prefix adder/subtractor with a valid/ready
// handshake on both sides.
//
// Pipeline layout (LAT = LEVELS + 2 register stages):
//   stage 0         : operand conditioning (p/g, carry-in folded into bit 0)
//   stages 1..LEVELS: one Kogge-Stone prefix level each
//   output stage    : sum / cout / ovf registers
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand beat valid
//   in_ready   out  beat is accepted this cycle (low only while stalled)
//   a, b       in   WIDTH-bit operands
//   cin        in   carry-in (add mode only)
//   sub        in   0: a + b + cin, 1: a - b (as a + ~b + 1)
//   out_valid  out  result beat valid
//   out_ready  in   consumer accepts the result
//   sum        out  WIDTH-bit result, modulo 2^WIDTH
//   cout       out  carry out of the MSB (sub: 1 = no borrow)
//   ovf        out  two's-complement overflow of the performed operation
// ---------------------------------------------------------------------------
module prefix_add_pipe #(
    parameter int WIDTH  = 8,
    parameter int LEVELS = $clog2(WIDTH),
    parameter int LAT    = LEVELS + 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] ONES = '1;

    // One prefix level at distance d: bits below d pass through, the rest
    // merge with the group ending d positions lower.
    function automatic logic [WIDTH-1:0] prefix_g(input logic [WIDTH-1:0] g,
                                                  input logic [WIDTH-1:0] p,
                                                  input int               d);
        return g | (p & (g << d));
    endfunction

    function automatic logic [WIDTH-1:0] prefix_p(input logic [WIDTH-1:0] p,
                                                  input int               d);
        // ~(ONES << d) keeps the low d bits of p untouched
        return p & ((p << d) | ~(ONES << d));
    endfunction

    // Global stall: one enable for every stage, so bubbles move with beats
    logic w_stall;
    assign w_stall   = out_valid & ~out_ready;
    assign in_ready  = ~w_stall;

    // Valid bits: index 0 = stage 0, LEVELS = last prefix level,
    // LAT-1 = output stage.
    logic [LAT-1:0] r_vld;

    // Datapath registers, indexed by stage (0 = input register)
    logic [WIDTH-1:0] r_g  [0:LEVELS];
    logic [WIDTH-1:0] r_pp [0:LEVELS-1];   // group propagate, not needed after the last level
    logic [WIDTH-1:0] r_p  [0:LEVELS];     // original bitwise propagate
    logic             r_c0 [0:LEVELS];
    logic             r_sa [0:LEVELS];
    logic             r_sb [0:LEVELS];

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    // ---- stage 0: operand conditioning ----
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_p_in;
    logic [WIDTH-1:0] w_g_in;
    logic             w_c0;

    always_comb begin
        w_b_eff = sub ? ~b : b;
        w_c0    = sub | cin;
        w_p_in  = a ^ w_b_eff;
        w_g_in  = a & w_b_eff;
        // Folding the carry-in into bit 0 makes G[i] the true carry out of bit i
        w_g_in[0] = w_g_in[0] | (w_p_in[0] & w_c0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else if (!w_stall) begin
            r_vld <= {r_vld[LAT-2:0], in_valid};
        end
    end

    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r_g[0]  <= w_g_in;
            r_pp[0] <= w_p_in;
            r_p[0]  <= w_p_in;
            r_c0[0] <= w_c0;
            r_sa[0] <= a[WIDTH-1];
            r_sb[0] <= w_b_eff[WIDTH-1];

            // ---- stages 1..LEVELS: prefix levels ----
            for (int k = 1; k <= LEVELS; k++) begin
                r_g[k]  <= prefix_g(r_g[k-1], r_pp[k-1], 1 << (k - 1));
                r_p[k]  <= r_p[k-1];
                r_c0[k] <= r_c0[k-1];
                r_sa[k] <= r_sa[k-1];
                r_sb[k] <= r_sb[k-1];
            end
            for (int k = 1; k < LEVELS; k++) begin
                r_pp[k] <= prefix_p(r_pp[k-1], 1 << (k - 1));
            end
        end
    end

    // ---- output stage ----
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;

    always_comb begin
        w_carry = {r_g[LEVELS][WIDTH-2:0], r_c0[LEVELS]};
        w_sum   = r_p[LEVELS] ^ w_carry;
        w_cout  = r_g[LEVELS][WIDTH-1];
        // Same as carry-into-MSB xor carry-out: equal operand signs and a
        // result sign that differs from them.
        w_ovf   = (r_sa[LEVELS] == r_sb[LEVELS]) & (w_sum[WIDTH-1] ^ r_sa[LEVELS]);
    end

    // Result registers only load real beats, so bubbles never disturb them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (!w_stall && r_vld[LEVELS]) begin
            r_sum  <= w_sum;
            r_cout <= w_cout;
            r_ovf  <= w_ovf;
        end
    end

    assign out_valid = r_vld[LAT-1];
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule
